// File: rtl/laplace_pkg.sv
// Shared types and constants for the bit-serial Laplace accumulate stage.
package laplace_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_W     = 8;
   localparam int DEF_ACC_W = 12;
   localparam int MAX_SHIFT = 2;

   // Shift codes above MAX_SHIFT saturate to MAX_SHIFT.
   function automatic logic [1:0] clamp_shift(input logic [1:0] shift);
      return (shift > 2'(MAX_SHIFT)) ? 2'(MAX_SHIFT) : shift;
   endfunction

endpackage

// File: rtl/laplace_serial_mac_fa_slice.sv
// One-bit adder slice with a registered carry; APPROX selects the approximate
// cell (sum forced low on the 1+1+1 input case) or the exact full adder.
module serial_fa_slice #(
   parameter bit APPROX = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic carry_load,
   input  logic carry_init,
   input  logic en,
   output logic s,
   output logic cout_q
);

   logic cout;

   // NOTE: every variable assigned in always_comb gets a value on every path
   // (here the plain assignments come first), otherwise a latch is inferred.
   always_comb begin
      cout = (a & b) | (cout_q & (a ^ b));
      s    = a ^ b ^ cout_q;
      if (APPROX && a && b && cout_q) begin
         s = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together at the clock edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cout_q <= 1'b0;
      end else if (carry_load) begin
         cout_q <= carry_init;
      end else if (en) begin
         cout_q <= cout;
      end
   end

endmodule

// File: rtl/laplace_serial_mac.sv
// Bit-serial signed accumulator for one Laplace kernel output: each term is
// shifted, optionally negated, and added LSB-first through a single slice.
module laplace_serial_mac
   import laplace_pkg::*;
#(
   parameter int W      = DEF_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter bit APPROX = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_pix,
   input  logic [1:0]       in_shift,
   input  logic             in_neg,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum
);

   localparam int               CNT_W    = $clog2(ACC_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, op;
   logic [ACC_W-1:0] shifted, operand;
   logic [CNT_W-1:0] cnt;
   logic             last_q;
   logic             accept, adding, add_done, sum_bit, carry_q;

   assign in_ready  = rst_n && (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_sum   = acc;
   assign accept    = in_valid && in_ready;
   assign adding    = (state == ADD);
   assign add_done  = adding && (cnt == CNT_LAST);

   // Negation is ones' complement here; the +1 enters through the carry seed.
   always_comb begin
      shifted = ACC_W'(in_pix) << clamp_shift(in_shift);
      operand = in_neg ? ~shifted : shifted;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept)    state_nxt = ADD;
         ADD:  if (add_done)  state_nxt = last_q ? DONE : IDLE;
         DONE: if (out_ready) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         op     <= '0;
         cnt    <= '0;
         last_q <= 1'b0;
      end else if (accept) begin
         op     <= operand;
         last_q <= in_last;
         cnt    <= '0;
      end else if (adding) begin
         acc <= {sum_bit, acc[ACC_W-1:1]};
         op  <= {1'b0, op[ACC_W-1:1]};
         cnt <= cnt + 1'b1;
      end else if (out_valid && out_ready) begin
         acc <= '0;
      end
   end

   // The carry left after the MSB is never consumed: the sum wraps mod 2^ACC_W.
   serial_fa_slice #(
      .APPROX(APPROX)
   ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (acc[0]),
      .b         (op[0]),
      .carry_load(accept),
      .carry_init(in_neg),
      .en        (adding),
      .s         (sum_bit),
      .cout_q    (carry_q)
   );

endmodule

// File: tb/tb_laplace_serial_mac.sv
// Scoreboard bench: exact-mode instance (directed + random) and approximate-mode
// instance (random), each checked against an arithmetic/truth-table reference.
module tb_laplace_serial_mac;
   import laplace_pkg::*;

   localparam int W     = 8;
   localparam int ACC_W = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic             in_valid  [2];
   logic             in_ready  [2];
   logic [W-1:0]     in_pix    [2];
   logic [1:0]       in_shift  [2];
   logic             in_neg    [2];
   logic             in_last   [2];
   logic             out_valid [2];
   logic             out_ready [2];
   logic [ACC_W-1:0] out_sum   [2];

   logic [ACC_W-1:0] q0[$];
   logic [ACC_W-1:0] q1[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic a_done = 1'b0;

   laplace_serial_mac #(.W(W), .ACC_W(ACC_W), .APPROX(1'b0)) dut_x (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pix(in_pix[0]),
      .in_shift(in_shift[0]), .in_neg(in_neg[0]), .in_last(in_last[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0])
   );

   laplace_serial_mac #(.W(W), .ACC_W(ACC_W), .APPROX(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pix(in_pix[1]),
      .in_shift(in_shift[1]), .in_neg(in_neg[1]), .in_last(in_last[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: term value from plain integer arithmetic.
   function automatic int term_int(input logic [W-1:0] pix, input logic [1:0] sh, input logic neg);
      int v;
      v = int'(pix) * ((sh == 2'd0) ? 1 : (sh == 2'd1) ? 2 : 4);
      return neg ? -v : v;
   endfunction

   // Reference: approximate cell applied bit by bit from its truth table,
   // indexed by {acc_bit, op_bit, carry}.
   function automatic logic [ACC_W-1:0] approx_add(input logic [ACC_W-1:0] acc_in,
                                                   input logic [W-1:0] pix,
                                                   input logic [1:0] sh, input logic neg);
      logic [7:0]       s_tab, c_tab;
      logic [ACC_W-1:0] opv, res;
      logic             c;
      logic [2:0]       idx;
      s_tab = 8'b0001_0110;
      c_tab = 8'b1110_1000;
      opv   = ACC_W'(term_int(pix, sh, 1'b0));
      if (neg) opv = ~opv;
      c = neg;
      for (int i = 0; i < ACC_W; i++) begin
         idx    = {acc_in[i], opv[i], c};
         res[i] = s_tab[idx];
         c      = c_tab[idx];
      end
      return res;
   endfunction

   task automatic push_exp(input int d, input logic [ACC_W-1:0] v);
      if (d == 0) q0.push_back(v);
      else        q1.push_back(v);
   endtask

   task automatic send(input int d, input logic [W-1:0] pix, input logic [1:0] sh,
                       input logic neg, input logic last);
      int waited = 0;
      in_pix[d]   = pix;
      in_shift[d] = sh;
      in_neg[d]   = neg;
      in_last[d]  = last;
      in_valid[d] = 1'b1;
      while (!in_ready[d] && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready[d]) check($sformatf("dut%0d_in_ready_timeout", d), 32'(in_ready[d]), 32'd1);
      @(negedge clk);
      in_valid[d] = 1'b0;
   endtask

   task automatic mon_step(input int d);
      logic [ACC_W-1:0] e;
      if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut%0d_unexpected_output: got 0x%0h with nothing queued", d, out_sum[d]);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d_out_sum", d), 32'(out_sum[d]), 32'(e));
         end
      end
   endtask

   always begin
      @(negedge clk);
      #1;
      mon_step(0);
      mon_step(1);
   end

   task automatic wait_out_valid(input int d, output int waited);
      waited = 0;
      while (!out_valid[d] && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("dut%0d_out_valid_timeout", d), 32'(out_valid[d]), 32'd1);
   endtask

   task automatic drain(input int d);
      int n = 0;
      while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("dut%0d_queue_drained", d), (d == 0) ? q0.size() : q1.size(), 32'd0);
   endtask

   task automatic stream_exact(input int n_sums);
      logic [31:0] sum;
      int          k;
      logic [W-1:0] pix;
      logic [1:0]   sh;
      logic         neg;
      for (int s = 0; s < n_sums; s++) begin
         k   = $urandom_range(1, 5);
         sum = '0;
         for (int t = 0; t < k; t++) begin
            pix = W'($urandom);
            sh  = 2'($urandom);
            neg = 1'($urandom);
            sum = sum + 32'(term_int(pix, sh, neg));
            if (t == k - 1) push_exp(0, sum[ACC_W-1:0]);
            send(0, pix, sh, neg, t == k - 1);
         end
      end
   endtask

   task automatic stream_approx(input int n_sums);
      logic [ACC_W-1:0] acc_m;
      logic [W-1:0]     pix;
      logic [1:0]       sh;
      logic             neg;
      for (int s = 0; s < n_sums; s++) begin
         acc_m = '0;
         for (int t = 0; t < 5; t++) begin
            pix   = W'($urandom);
            sh    = 2'($urandom);
            neg   = 1'($urandom);
            acc_m = approx_add(acc_m, pix, sh, neg);
            if (t == 4) push_exp(1, acc_m);
            send(1, pix, sh, neg, t == 4);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start_cyc, waited, seen;
      logic [ACC_W-1:0] held;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b0;
         in_pix[d]    = '0;
         in_shift[d]  = '0;
         in_neg[d]    = 1'b0;
         in_last[d]   = 1'b0;
         out_ready[d] = 1'b1;
      end

      // Reset state
      #1;
      check("reset_in_ready", 32'(in_ready[0]), 32'd0);
      check("reset_out_valid", 32'(out_valid[0]), 32'd0);
      check("reset_out_sum", 32'(out_sum[0]), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("idle_in_ready", 32'(in_ready[0]), 32'd1);
      @(negedge clk);

      // 4*C - N - S - E - W with latency from first accept to out_valid
      start_cyc = cyc;
      push_exp(0, 12'h00E);
      send(0, 8'd10, 2'd2, 1'b0, 1'b0);
      send(0, 8'd5,  2'd0, 1'b1, 1'b0);
      send(0, 8'd6,  2'd0, 1'b1, 1'b0);
      send(0, 8'd7,  2'd0, 1'b1, 1'b0);
      send(0, 8'd8,  2'd0, 1'b1, 1'b1);
      wait_out_valid(0, waited);
      check("latency_5_terms", cyc - start_cyc, 32'(5 * (ACC_W + 1)));
      drain(0);

      // Fully negative neighbourhood
      push_exp(0, 12'hC04);
      send(0, 8'd0, 2'd2, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 8'd255, 2'd0, 1'b1, i == 3);
      drain(0);

      // Single-term sum, then large positive sums with wrap; shift code 3 acts as 2
      push_exp(0, 12'h3FC);
      send(0, 8'd255, 2'd2, 1'b0, 1'b1);
      push_exp(0, 12'hBF4);
      send(0, 8'd255, 2'd2, 1'b0, 1'b0);
      send(0, 8'd255, 2'd3, 1'b0, 1'b0);
      send(0, 8'd255, 2'd2, 1'b0, 1'b1);
      push_exp(0, 12'h3EC);
      for (int i = 0; i < 5; i++) send(0, 8'd255, 2'd2, 1'b0, i == 4);
      drain(0);

      // Backpressure: result held, in_valid ignored, then cleared on release
      out_ready[0] = 1'b0;
      push_exp(0, 12'h064);
      send(0, 8'd100, 2'd0, 1'b0, 1'b1);
      wait_out_valid(0, waited);
      held = out_sum[0];
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid[0] = 1'(i % 2);
         in_pix[0]   = W'($urandom);
         in_last[0]  = 1'b1;
         check("stall_out_valid", 32'(out_valid[0]), 32'd1);
         check("stall_out_sum", 32'(out_sum[0]), 32'(held));
         check("stall_in_ready", 32'(in_ready[0]), 32'd0);
      end
      @(negedge clk);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      check("release_out_valid", 32'(out_valid[0]), 32'd0);
      check("release_acc_cleared", 32'(out_sum[0]), 32'd0);
      check("release_in_ready", 32'(in_ready[0]), 32'd1);
      push_exp(0, 12'h007);
      send(0, 8'd7, 2'd0, 1'b0, 1'b1);
      drain(0);

      // Reset in the middle of ADD drops the partial sum
      send(0, 8'd200, 2'd1, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_in_ready", 32'(in_ready[0]), 32'd0);
      check("midreset_out_valid", 32'(out_valid[0]), 32'd0);
      check("midreset_out_sum", 32'(out_sum[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("postreset_in_ready", 32'(in_ready[0]), 32'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid[0]) seen++;
      end
      check("postreset_no_output", seen, 32'd0);
      push_exp(0, 12'h003);
      send(0, 8'd3, 2'd0, 1'b0, 1'b1);
      drain(0);

      // Random sums on both instances in parallel
      @(negedge clk);
      fork
         stream_exact(200);
         begin
            stream_approx(1000);
            a_done = 1'b1;
         end
         begin
            while (!a_done) begin
               @(negedge clk);
               out_ready[1] = ($urandom_range(0, 3) != 0);
            end
            out_ready[1] = 1'b1;
         end
      join
      drain(0);
      drain(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/laplace_serial_mac.md
Name: laplace_serial_mac

Overview:
Bit-serial accumulate stage that feeds the team's 1-bit approximate full-adder cell. It accumulates the signed, shifted terms of one Laplace kernel output, for example 4*C − N − S − E − W. Each accepted pixel term is serialised LSB-first through a single full-adder slice with a registered carry. The finished two's-complement sum is presented on a valid/ready output to the downstream thresholding/clamp stage.

Parameters:
W, 8, pixel width in bits (unsigned input).
ACC_W, 12, accumulator/result width, two's complement; must be ≥ W+3.
APPROX, 1, 1 = approximate full-adder cell in the slice, 0 = exact full adder (golden/verification mode).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  term present on in_* fields.
in_ready  output  1  block can accept a term this cycle.
in_pix  input  W  unsigned pixel value.
in_shift  input  2  left-shift amount 0..2; value 3 is treated as 2.
in_neg  input  1  1 = subtract term, 0 = add.
in_last  input  1  final term of the current kernel sum.
out_valid  output  1  out_sum holds a completed kernel sum.
out_ready  input  1  downstream accepts out_sum.
out_sum  output  ACC_W  accumulated result, two's complement.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, accumulator=0, carry FF=0, bit counter=0, last flag=0. Outputs: in_ready=0 while rst_n=0, then 1 in IDLE; out_valid=0; out_sum=0.
- States: IDLE, ADD, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE: on in_valid&in_ready:
  - operand = zero_extend(in_pix, ACC_W) << in_shift; if in_neg, operand is bitwise inverted.
  - operand, in_neg and in_last are captured.
  - carry FF = in_neg (the +1 of two's-complement negation).
  - bit counter = 0; go to ADD.
- ADD: one bit per cycle, LSB first, for ACC_W cycles (counter 0..ACC_W−1).
  - Slice computes S, Cout from acc[0], op[0], carry.
  - Accumulator and operand shift right by one; S enters accumulator MSB.
  - carry ← Cout.
  - At counter==ACC_W−1: final Cout is discarded (modulo 2^ACC_W wrap, no saturation). Next state is DONE if captured last=1, else IDLE.
- Throughput: one term per ACC_W+1 cycles (1 accept cycle + ACC_W add cycles).
- DONE: out_sum = accumulator, stable while out_valid=1 and out_ready=0. On out_ready=1: accumulator ← 0, state ← IDLE, out_valid deasserts next cycle.
- in_valid while not in IDLE is ignored; the upstream producer holds its term until it sees in_ready.
- out_ready while not in DONE is ignored.
- A term with in_last=1 on the first term of a sum is legal (single-term result).
- Reset asserted mid-ADD or mid-DONE aborts immediately. Partial sum is lost; no output is produced.
- out_sum is the registered accumulator and changes only in ADD (shifting) and on DONE exit (cleared). Consumers sample it only while out_valid=1.

Decomposition:
- Package laplace_pkg:
  - state enum {IDLE, ADD, DONE};
  - default W/ACC_W constants;
  - MAX_SHIFT=2.
- Sub-module serial_fa_slice: one full-adder cell plus carry FF.
  - Inputs: clk, rst_n, a, b, carry_load, carry_init, en.
  - Outputs: s, cout_q.
  - APPROX selects the approximate cell or the exact equations.
- The top level holds the FSM, bit counter and the operand/accumulator shift registers.

Test Plan:
- APPROX=0. Terms (10, shift 2, +), (5,−), (6,−), (7,−), (8,− last) → out_valid after 5×13 cycles, out_sum=0x00E (14).
- APPROX=0. C=0 shift 2, then four neighbours 255 subtracted → out_sum=0xC04 (−1020).
- APPROX=0. Single term 255, shift 2, +, last → out_sum=0x3FC. Then 255 shift 2 ×3 + last → wraps to 0xBF4 (3060 mod 4096); final carry discarded.
- out_ready held 0 for 20 cycles in DONE → out_sum and out_valid stable; in_valid pulses ignored; in_ready=0 throughout. Release → accumulator cleared, next sum starts from 0.
- rst_n pulsed low in ADD cycle 5 → out_valid=0, in_ready=1 after release. Next single term 3, +, last → out_sum=0x003.
- APPROX=1, random 1000 five-term sums → out_sum matches a bit-serial reference model built on the approximate cell truth table, bit-exact.
